// File: rtl/scpu_pkg.sv
// Shared sCPU constants and types for the register-file write path.
// Imported by reg_writeback and its decoder.
package scpu_pkg;

    localparam int DATA_W   = 8;
    localparam int REG_W    = 2;
    localparam int NUM_REGS = 1 << REG_W;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam reg_idx_t R0 = 2'd0;
    localparam reg_idx_t R1 = 2'd1;
    localparam reg_idx_t R2 = 2'd2;
    localparam reg_idx_t R3 = 2'd3;

    // One in-flight write between capture and commit.
    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        data_t    data;
    } stage_t;

endpackage

// File: rtl/decoder_2to4.sv
// Qualified 2-to-4 one-hot decoder: selects one register when en is high,
// drives all zeros otherwise.
module decoder_2to4
    import scpu_pkg::*;
(
    input  logic                en,
    input  logic [REG_W-1:0]    sel,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        // NOTE: default assigned first so every path drives onehot; no latch.
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write side of the sCPU 4x8 register file: one-cycle staging, commit into the
// addressed register, and a per-register busy scoreboard for RAW detection.
module reg_writeback
    import scpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [REG_W-1:0]    rd,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                issue_en,
    input  logic [REG_W-1:0]    issue_rd,
    output logic [DATA_W-1:0]   reg0_out,
    output logic [DATA_W-1:0]   reg1_out,
    output logic [DATA_W-1:0]   reg2_out,
    output logic [DATA_W-1:0]   reg3_out,
    output logic [NUM_REGS-1:0] busy,
    output logic                wr_ack,
    output logic [REG_W-1:0]    wr_ack_rd
);

    stage_t              stg;
    data_t               regs [NUM_REGS];
    logic [NUM_REGS-1:0] commit_oh;
    logic [NUM_REGS-1:0] issue_oh;

    // commit_oh doubles as the write enable and the scoreboard clear.
    decoder_2to4 u_commit_dec (
        .en     (stg.valid),
        .sel    (stg.rd),
        .onehot (commit_oh)
    );

    decoder_2to4 u_issue_dec (
        .en     (issue_en),
        .sel    (issue_rd),
        .onehot (issue_oh)
    );

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so all flops see pre-edge values.
        if (rst) begin
            stg <= '0;
        end else begin
            stg.valid <= wr_en;
            if (wr_en) begin
                stg.rd   <= rd;
                stg.data <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the register file must read 0x00 out of reset, so this array
        // is reset explicitly (it is four flops wide, not a RAM macro).
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_oh[i]) begin
                    regs[i] <= stg.data;
                end
            end
        end
    end

    // Set wins over clear: an issue on the committing register is a newer write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~commit_oh) | issue_oh;
        end
    end

    assign wr_ack    = stg.valid;
    assign wr_ack_rd = stg.rd;

    assign reg0_out = regs[R0];
    assign reg1_out = regs[R1];
    assign reg2_out = regs[R2];
    assign reg3_out = regs[R3];

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed table, reset corner cases,
// and randomized traffic against a queue-based reference model.
module tb_reg_writeback;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] rd;
    logic [7:0] wr_data;
    logic       issue_en;
    logic [1:0] issue_rd;
    logic [7:0] reg0_out, reg1_out, reg2_out, reg3_out;
    logic [3:0] busy;
    logic       wr_ack;
    logic [1:0] wr_ack_rd;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd        (rd),
        .wr_data   (wr_data),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .reg0_out  (reg0_out),
        .reg1_out  (reg1_out),
        .reg2_out  (reg2_out),
        .reg3_out  (reg3_out),
        .busy      (busy),
        .wr_ack    (wr_ack),
        .wr_ack_rd (wr_ack_rd)
    );

    typedef struct {
        logic        we;
        logic [1:0]  rd;
        logic [7:0]  data;
        logic        ie;
        logic [1:0]  ird;
        logic [3:0]  exp_busy;
        logic        exp_ack;
        logic [1:0]  exp_ack_rd;
        logic [31:0] exp_regs;  // {reg3, reg2, reg1, reg0}
    } vec_t;

    vec_t vecs [19];

    // Reference model: writes wait in a queue for exactly one edge.
    typedef struct {
        logic [1:0] rd;
        logic [7:0] data;
    } wr_t;

    wr_t        inflight [$];
    logic [7:0] m_regs [4];
    bit         m_busy [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_regs();
        return {reg3_out, reg2_out, reg1_out, reg0_out};
    endfunction

    task automatic drive(input logic we, input logic [1:0] r, input logic [7:0] d,
                         input logic ie, input logic [1:0] ir);
        wr_en = we; rd = r; wr_data = d; issue_en = ie; issue_rd = ir;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        inflight.delete();
        for (int i = 0; i < 4; i++) begin
            m_regs[i] = 8'h00;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(input bit we, input logic [1:0] r, input logic [7:0] d,
                                       input bit ie, input logic [1:0] ir);
        wr_t w;
        bit  has_clr = 1'b0;
        int  clr_idx = 0;
        if (inflight.size() > 0) begin
            w = inflight.pop_front();
            m_regs[w.rd] = w.data;
            has_clr = 1'b1;
            clr_idx = int'(w.rd);
        end
        for (int i = 0; i < 4; i++) begin
            if (ie && int'(ir) == i)           m_busy[i] = 1'b1;
            else if (has_clr && clr_idx == i)  m_busy[i] = 1'b0;
        end
        if (we) inflight.push_back('{r, d});
    endfunction

    task automatic check_model(input string tag);
        logic [3:0] exp_busy;
        for (int i = 0; i < 4; i++) exp_busy[i] = m_busy[i];
        check({tag, " busy"}, 32'(busy), 32'(exp_busy));
        check({tag, " wr_ack"}, 32'(wr_ack), 32'(inflight.size() != 0));
        if (inflight.size() != 0) check({tag, " wr_ack_rd"}, 32'(wr_ack_rd), 32'(inflight[0].rd));
        check({tag, " regs"}, dut_regs(), {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    endtask

    initial begin
        // Directed table: inputs for one edge, then outputs expected after it.
        vecs[0]  = '{1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd2, 32'h00000000};
        vecs[1]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 32'h00A50000};
        vecs[2]  = '{1'b1, 2'd0, 8'h11, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 32'h00A50000};
        vecs[3]  = '{1'b1, 2'd1, 8'h22, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 32'h00A50011};
        vecs[4]  = '{1'b1, 2'd1, 8'h33, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 32'h00A52211};
        vecs[5]  = '{1'b1, 2'd3, 8'h44, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd3, 32'h00A53311};
        vecs[6]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 32'h44A53311};
        vecs[7]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 4'b0010, 1'b0, 2'd0, 32'h44A53311};
        vecs[8]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'b0010, 1'b0, 2'd0, 32'h44A53311};
        vecs[9]  = '{1'b1, 2'd1, 8'h55, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 32'h44A53311};
        vecs[10] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 32'h44A55511};
        vecs[11] = '{1'b1, 2'd3, 8'h66, 1'b1, 2'd3, 4'b1000, 1'b1, 2'd3, 32'h44A55511};
        vecs[12] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 4'b1000, 1'b0, 2'd0, 32'h66A55511};
        vecs[13] = '{1'b1, 2'd3, 8'h77, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3, 32'h66A55511};
        vecs[14] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 32'h77A55511};
        vecs[15] = '{1'b1, 2'd3, 8'h88, 1'b1, 2'd3, 4'b1000, 1'b1, 2'd3, 32'h77A55511};
        vecs[16] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 4'b0001, 1'b0, 2'd0, 32'h88A55511};
        vecs[17] = '{1'b1, 2'd0, 8'h99, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 32'h88A55511};
        vecs[18] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 32'h88A55599};

        rst = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        #2;
        check("reset regs", dut_regs(), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset wr_ack", 32'(wr_ack), 32'h0);
        check("reset wr_ack_rd", 32'(wr_ack_rd), 32'h0);
        #10 rst = 1'b0;                      // released mid-cycle
        tick();
        check("post-reset wr_ack", 32'(wr_ack), 32'h0);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].we, vecs[i].rd, vecs[i].data, vecs[i].ie, vecs[i].ird);
            tick();
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d wr_ack", i), 32'(wr_ack), 32'(vecs[i].exp_ack));
            if (vecs[i].exp_ack)
                check($sformatf("vec%0d wr_ack_rd", i), 32'(wr_ack_rd), 32'(vecs[i].exp_ack_rd));
            check($sformatf("vec%0d regs", i), dut_regs(), vecs[i].exp_regs);
        end

        // Async reset mid-cycle with a write staged and a register busy.
        drive(1'b1, 2'd1, 8'hC3, 1'b1, 2'd2);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        check("pre-async wr_ack", 32'(wr_ack), 32'h1);
        check("pre-async busy", 32'(busy), 32'b0100);
        #2 rst = 1'b1;
        #1;
        check("async regs", dut_regs(), 32'h0);
        check("async busy", 32'(busy), 32'h0);
        check("async wr_ack", 32'(wr_ack), 32'h0);
        #1 rst = 1'b0;
        tick();
        check("async after-edge regs", dut_regs(), 32'h0);
        check("async after-edge wr_ack", 32'(wr_ack), 32'h0);

        // Reset pulsed between capture and commit discards the write.
        drive(1'b1, 2'd1, 8'hFF, 1'b0, 2'd0);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        check("midwrite wr_ack", 32'(wr_ack), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("midwrite c%0d reg1", c), 32'(reg1_out), 32'h0);
            check($sformatf("midwrite c%0d wr_ack", c), 32'(wr_ack), 32'h0);
            check($sformatf("midwrite c%0d busy", c), 32'(busy), 32'h0);
        end

        // Randomized traffic against the reference model.
        model_reset();
        for (int c = 0; c < 400; c++) begin
            logic       we, ie;
            logic [1:0] r, ir;
            logic [7:0] d;
            if ($urandom_range(59) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check($sformatf("rnd%0d async regs", c), dut_regs(), 32'h0);
                check($sformatf("rnd%0d async busy", c), 32'(busy), 32'h0);
                rst = 1'b0;
            end
            we = ($urandom_range(3) != 0);
            r  = 2'($urandom_range(3));
            d  = 8'($urandom);
            ie = ($urandom_range(2) == 0);
            ir = 2'($urandom_range(3));
            drive(we, r, d, ie, ir);
            model_edge(we, r, d, ie, ir);
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
Write side of the sCPU 4x8-bit register file: accepts a destination select (rd) plus result data, stages it one cycle, then commits it into the addressed register. Exposes all four register values to the read-operand selector. Keeps a per-register busy scoreboard so the control path can detect read-after-write hazards on in-flight writes. Sits between the ALU/result path and the operand selector.

Parameters:
DATA_W, 8, register data width
REG_W, 2, destination select width; NUM_REGS = 2**REG_W = 4

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
wr_en  input  1  write request this cycle
rd  input  REG_W  destination register for wr_en
wr_data  input  DATA_W  result data for wr_en
issue_en  input  1  instruction with destination issued this cycle; marks rd busy
issue_rd  input  REG_W  destination of issued instruction
reg0_out  output  DATA_W  register 0 contents
reg1_out  output  DATA_W  register 1 contents
reg2_out  output  DATA_W  register 2 contents
reg3_out  output  DATA_W  register 3 contents
busy  output  NUM_REGS  bit i = register i has a write pending
wr_ack  output  1  commit occurring this cycle
wr_ack_rd  output  REG_W  register being committed (valid while wr_ack)

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset: all registers 0x00; staging valid 0; busy 4'b0000; wr_ack 0; wr_ack_rd 0. Assertion mid-operation discards any staged write and clears all busy bits. No commit in the first cycle after rst deasserts unless wr_en was sampled high.
- Stage 1 (capture): on rising edge with wr_en=1, latch stg_valid=1, stg_rd=rd, stg_data=wr_data. With wr_en=0, stg_valid<=0.
- Stage 2 (commit): while stg_valid=1, wr_ack=1 and wr_ack_rd=stg_rd, both driven directly from flops. On that edge, regs[stg_rd]<=stg_data.
- Latency: wr_en sampled at edge N. wr_ack is high during cycle N+1. regN_out shows the new value from edge N+2.
- Throughput: one write per cycle, fully pipelined, no stall, no backpressure. Back-to-back writes to the same rd commit in order; the last write wins.
- Write decode: a one-hot enable is derived from stg_rd. Exactly one register is written per commit; the other registers hold.
- Outputs regN_out are direct register contents. There is no bypass/forwarding; the consumer checks busy.
- Scoreboard, per bit i, evaluated each edge:
  - set_i = issue_en & (issue_rd==i)
  - clr_i = stg_valid & (stg_rd==i)
  - Next value: set_i ? 1 : clr_i ? 0 : hold.
  - Simultaneous set and clear on the same register: set wins (a newer write is in flight).
  - Set and clear on different registers both take effect.
- Commit to a register that is not busy (write without a prior issue) is legal. The register is written and busy stays 0.
- All four registers, including reg0, are writable. There is no hard-wired zero.
- Data width: no truncation or extension. wr_data is stored bit-exact.

Decomposition:
- Shared package (scpu_pkg):
  - DATA_W=8, REG_W=2, NUM_REGS=4
  - register index constants R0..R3
- Sub-module decoder_2to4: stg_rd plus stg_valid produce a 4-bit one-hot write enable. It is reused by the scoreboard set/clear logic (two instances).
- The register array, staging flops and scoreboard live in reg_writeback.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> reg0..3_out=0x00, busy=0000, wr_ack=0 immediately, with no clock edge needed.
- Single write: wr_en=1, rd=2, wr_data=0xA5 at edge N -> wr_ack=1, wr_ack_rd=2 in cycle N+1; reg2_out=0xA5 from N+2; reg0/1/3 unchanged at 0x00.
- Back-to-back: edges N..N+3 write rd=0:0x11, rd=1:0x22, rd=1:0x33, rd=3:0x44 -> wr_ack high for cycles N+1..N+4; final reg0=0x11, reg1=0x33, reg3=0x44, reg2 untouched.
- Scoreboard: issue_en, issue_rd=1 at edge N -> busy=0010 from N+1; wr_en rd=1 at N+2 -> busy returns to 0000 after edge N+3.
- Set/clear collision: commit of rd=3 and issue_en, issue_rd=3 on the same edge -> busy[3] stays 1. Same test with issue_rd=0 -> busy=0001.
- Reset mid-write: wr_en rd=1, 0xFF at edge N, rst pulsed before edge N+1 -> reg1_out stays 0x00, wr_ack never asserts, busy=0000.
